axi_reg_arbiter: RTL and testbench

Shares one AXI4-Lite master port between N_REQ local requesters, each using a simple valid/ready command interface. It sits in front of the AXI4-Lite register bank (4 x 32-bit registers at 0x0/0x4/0x8/0xC). Round-robin arbitration picks one requester, which gets a single complete register read or write. Exactly one transaction is outstanding at a time.

---
 rtl/axi_reg_arb_pkg.sv | 24 ++
 rtl/axi_reg_arbiter_rr.sv | 30 +++
 rtl/axi_reg_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_axi_reg_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_reg_arb_pkg.sv
// Shared types and constants for the AXI4-Lite register-bank arbiter.
package axi_reg_arb_pkg;

  localparam int unsigned AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
  localparam logic [3:0] WSTRB_ALL    = 4'b1111;

  // Completion payload returned to the granted requester.
  typedef struct packed {
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            resp;
  } rsp_t;

endpackage

// File: rtl/axi_reg_arbiter_rr.sv
// Combinational round-robin picker: first request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt_oh_c,
  output logic [IDX_W-1:0] gnt_idx_c,
  output logic             gnt_any_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    cand      = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = IDX_W'((32'(rr_ptr) + off) % N_REQ);
      if (!gnt_any_c && req[cand]) begin
        gnt_any_c       = 1'b1;
        gnt_idx_c       = cand;
        gnt_oh_c[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_reg_arbiter.sv
// Shares one AXI4-Lite master among N_REQ requesters; one transaction in flight,
// round-robin grant, one-cycle completion pulse back to the winner.
module axi_reg_arbiter
  import axi_reg_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0]              req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  rsp_t                  rsp_q, rsp_d;

  logic [N_REQ-1:0]      gnt_oh_c;
  logic [IDX_W-1:0]      gnt_idx_c;
  logic                  gnt_any_c;
  logic                  sel_write_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic                  aw_done_c, w_done_c;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt_oh_c  (gnt_oh_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  // Pick the winning requester's command fields.
  always_comb begin
    sel_write_c = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx_c == IDX_W'(i)) begin
        sel_write_c = req_write[i];
        sel_addr_c  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_c = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A channel counts as done once its valid is gone or it handshakes now.
  assign aw_done_c = !awvalid_q || M_AXI_AWREADY;
  assign w_done_c  = !wvalid_q  || M_AXI_WREADY;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = '0;
    rsp_d       = rsp_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        if (gnt_any_c) begin
          req_ready = gnt_oh_c;
          gnt_d     = gnt_idx_c;
          write_d   = sel_write_c;
          addr_d    = sel_addr_c;
          wdata_d   = sel_wdata_c;
          rr_ptr_d  = IDX_W'((32'(gnt_idx_c) + 32'd1) % N_REQ);
          awvalid_d = sel_write_c;
          wvalid_d  = sel_write_c;
          arvalid_d = !sel_write_c;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (write_q) begin
          if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
          if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
          if (aw_done_c && w_done_c) begin
            bready_d = 1'b1;
            state_d  = RESP;
          end
        end else if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (write_q && M_AXI_BVALID) begin
          bready_d           = 1'b0;
          rsp_d.rdata        = '0;
          rsp_d.resp         = M_AXI_BRESP;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = DONE;
        end else if (!write_q && M_AXI_RVALID) begin
          rready_d           = 1'b0;
          rsp_d.rdata        = M_AXI_RDATA;
          rsp_d.resp         = M_AXI_RRESP;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_q.rdata;
  assign rsp_resp      = rsp_q.resp;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = WSTRB_ALL;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_reg_arbiter.sv
// Directed bench for axi_reg_arbiter with a delay-configurable 4-register AXI4-Lite slave.
module tb_axi_reg_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            ACLK    = 1'b0;
  logic            ARESETN = 1'b1;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [31:0]     rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [31:0]     wdata, rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;

  axi_reg_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  // Slave: readies/valids gated by per-channel wait counters.
  logic [31:0] regs [4];
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic        err_mode = 1'b0;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_seen, w_seen, b_pend, r_pend;
  logic [3:0]  aw_a;
  logic [31:0] w_d, r_d;
  logic        aw_hs, w_hs, ar_hs;
  logic [3:0]  wr_addr_c;
  logic [31:0] wr_data_c;

  assign awready   = awvalid && (aw_cnt >= aw_delay);
  assign wready    = wvalid && (w_cnt >= w_delay);
  assign arready   = arvalid && (ar_cnt >= ar_delay);
  assign bvalid    = b_pend && (b_cnt >= b_delay);
  assign rvalid    = r_pend && (r_cnt >= r_delay);
  assign bresp     = err_mode ? 2'b10 : 2'b00;
  assign rresp     = err_mode ? 2'b10 : 2'b00;
  assign rdata     = r_d;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign ar_hs     = arvalid && arready;
  assign wr_addr_c = aw_hs ? awaddr : aw_a;
  assign wr_data_c = w_hs ? wdata : w_d;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_a <= '0; w_d <= '0; r_d <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else if (aw_hs) aw_cnt <= 0;
      if (wvalid && !wready)   w_cnt  <= w_cnt + 1;  else if (w_hs)  w_cnt  <= 0;
      if (arvalid && !arready) ar_cnt <= ar_cnt + 1; else if (ar_hs) ar_cnt <= 0;
      if (aw_hs) begin aw_seen <= 1'b1; aw_a <= awaddr; end
      if (w_hs)  begin w_seen  <= 1'b1; w_d  <= wdata;  end
      if ((aw_hs || aw_seen) && (w_hs || w_seen)) begin
        regs[wr_addr_c[3:2]] <= wr_data_c;
        aw_seen <= 1'b0; w_seen <= 1'b0;
        b_pend  <= 1'b1; b_cnt  <= 0;
      end else if (b_pend) begin
        if (bvalid && bready) b_pend <= 1'b0; else b_cnt <= b_cnt + 1;
      end
      if (ar_hs) begin
        r_pend <= 1'b1; r_cnt <= 0; r_d <= regs[araddr[3:2]];
      end else if (r_pend) begin
        if (rvalid && rready) r_pend <= 1'b0; else r_cnt <= r_cnt + 1;
      end
    end
  end

  // Monitor: logs grants, completions and channel events mid-cycle.
  int          cyc = 0;
  int          n_gnt = 0, n_rsp = 0, n_bready = 0, n_bhs = 0;
  int          gnt_idx_log [64];
  int          gnt_cyc_log [64];
  int          rsp_cyc_log [64];
  int          aw_fall_cyc = -1, w_fall_cyc = -1;
  logic        aw_prev = 1'b0, w_prev = 1'b0;
  logic [3:0]  cap_awaddr = '0, cap_wstrb = '0;
  logic [31:0] cap_wdata = '0;

  always @(posedge ACLK) cyc <= cyc + 1;

  always begin
    @(negedge ACLK);
    #2;
    if (|req_ready && n_gnt < 64) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) gnt_idx_log[n_gnt] = i;
      gnt_cyc_log[n_gnt] = cyc;
      n_gnt++;
    end
    if (|rsp_valid && n_rsp < 64) begin
      rsp_cyc_log[n_rsp] = cyc;
      n_rsp++;
    end
    if (bready) n_bready++;
    if (bvalid && bready) n_bhs++;
    if (aw_hs) cap_awaddr = awaddr;
    if (w_hs) begin cap_wdata = wdata; cap_wstrb = wstrb; end
    if (aw_prev && !awvalid) aw_fall_cyc = cyc;
    if (w_prev && !wvalid)   w_fall_cyc  = cyc;
    aw_prev = awvalid;
    w_prev  = wvalid;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic wr, input logic [3:0] a, input logic [31:0] d);
    req_write[i]           = wr;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_valid[i]           = 1'b1;
  endtask

  task automatic wait_gnt(input int i, output int gc);
    gc = -1;
    for (int k = 0; k < 60 && gc < 0; k++) begin
      #1;
      if (req_ready[i]) gc = cyc; else @(negedge ACLK);
    end
    if (gc < 0) check("gnt_timeout", 32'(i), 32'hFFFF_FFFF);
  endtask

  task automatic wait_rsp(input int i, output int rc);
    rc = -1;
    for (int k = 0; k < 60 && rc < 0; k++) begin
      #1;
      if (rsp_valid[i]) rc = cyc; else @(negedge ACLK);
    end
    if (rc < 0) check("rsp_timeout", 32'(i), 32'hFFFF_FFFF);
  endtask

  task automatic start_cmd(input int i, input logic wr, input logic [3:0] a, input logic [31:0] d,
                           output int gc);
    @(negedge ACLK);
    drive(i, wr, a, d);
    wait_gnt(i, gc);
    @(negedge ACLK);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    int gc, rc, gc0, rc0, base, rbase, b0, bhs0, k;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    #1 ARESETN = 1'b0;
    #11;
    check("rst_axi_handshake", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_resp", 32'(rsp_resp), 32'h0);
    check("const_prot_strb", 32'({awprot, arprot, wstrb}), 32'h00F);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // Single write from requester 0.
    start_cmd(0, 1'b1, 4'h4, 32'hDEAD_BEEF, gc);
    wait_rsp(0, rc);
    check("wr_latency", 32'(rc - gc), 32'd3);
    check("wr_awaddr", 32'(cap_awaddr), 32'h4);
    check("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("wr_wstrb", 32'(cap_wstrb), 32'hF);
    check("wr_rsp_resp", 32'(rsp_resp), 32'h0);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_slave_reg1", regs[1], 32'hDEAD_BEEF);

    // Read-back from requester 1.
    start_cmd(1, 1'b0, 4'h4, 32'h0, gc);
    wait_rsp(1, rc);
    check("rd_latency", 32'(rc - gc), 32'd3);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_resp", 32'(rsp_resp), 32'h0);
    check("rd_rsp_onehot", 32'(rsp_valid), 32'h2);

    // Contention: both requesters continuously valid.
    @(negedge ACLK);
    base = n_gnt; rbase = n_rsp;
    drive(0, 1'b1, 4'h0, 32'hA0A0_A0A0);
    drive(1, 1'b1, 4'h8, 32'hB1B1_B1B1);
    k = 0;
    while (n_gnt < base + 4 && k < 80) begin @(negedge ACLK); #3; k++; end
    @(negedge ACLK);
    req_valid = '0;
    k = 0;
    while (n_rsp < rbase + 4 && k < 80) begin @(negedge ACLK); #3; k++; end
    check("cont_gnt_count", 32'(n_gnt - base), 32'd4);
    check("cont_rsp_count", 32'(n_rsp - rbase), 32'd4);
    for (int j = 0; j < 4; j++) check("cont_gnt_order", 32'(gnt_idx_log[base + j]), 32'(j % 2));
    check("cont_span", 32'(rsp_cyc_log[rbase + 3] - gnt_cyc_log[base]), 32'd15);
    check("cont_reg0", regs[0], 32'hA0A0_A0A0);
    check("cont_reg2", regs[2], 32'hB1B1_B1B1);

    // Handshake order: AWREADY late, WREADY immediate.
    @(negedge ACLK);
    aw_delay = 3; w_delay = 0; bhs0 = n_bhs; rbase = n_rsp;
    start_cmd(0, 1'b1, 4'hC, 32'h1234_5678, gc);
    wait_rsp(0, rc);
    #2;
    check("awlate_latency", 32'(rc - gc), 32'd6);
    check("awlate_w_fall", 32'(w_fall_cyc - gc), 32'd2);
    check("awlate_aw_fall", 32'(aw_fall_cyc - gc), 32'd5);
    check("awlate_bhs", 32'(n_bhs - bhs0), 32'd1);
    check("awlate_rsp", 32'(n_rsp - rbase), 32'd1);

    // Reverse order: WREADY late.
    aw_delay = 0; w_delay = 3; bhs0 = n_bhs; rbase = n_rsp;
    start_cmd(1, 1'b1, 4'hC, 32'h8765_4321, gc);
    wait_rsp(1, rc);
    #2;
    check("wlate_latency", 32'(rc - gc), 32'd6);
    check("wlate_aw_fall", 32'(aw_fall_cyc - gc), 32'd2);
    check("wlate_w_fall", 32'(w_fall_cyc - gc), 32'd5);
    check("wlate_bhs", 32'(n_bhs - bhs0), 32'd1);
    check("wlate_rsp", 32'(n_rsp - rbase), 32'd1);
    check("wlate_reg3", regs[3], 32'h8765_4321);
    w_delay = 0;

    // Backpressure on B; a waiting requester must not be granted early.
    b_delay = 5;
    b0 = n_bready;
    start_cmd(1, 1'b1, 4'h8, 32'hCAFE_F00D, gc);
    drive(0, 1'b0, 4'h4, 32'h0);
    wait_rsp(1, rc);
    check("bp_latency", 32'(rc - gc), 32'd8);
    check("bp_bready_cycles", 32'(n_bready - b0), 32'd6);
    wait_gnt(0, gc0);
    check("bp_next_gnt", 32'(gc0 - gc), 32'd9);
    @(negedge ACLK);
    req_valid[0] = 1'b0;
    b_delay = 0;
    wait_rsp(0, rc0);
    check("bp_rd_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // SLVERR on a read passes through and holds afterwards.
    err_mode = 1'b1;
    start_cmd(1, 1'b0, 4'h8, 32'h0, gc);
    wait_rsp(1, rc);
    check("err_rsp_resp", 32'(rsp_resp), 32'h2);
    check("err_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    err_mode = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    check("err_hold_resp", 32'(rsp_resp), 32'h2);
    check("err_hold_rdata", rsp_rdata, 32'hCAFE_F00D);

    // Reset while AWVALID is up: transaction abandoned, rr pointer cleared.
    aw_delay = 10;
    start_cmd(0, 1'b1, 4'h0, 32'h5555_5555, gc);
    #1;
    check("rst_mid_awvalid_pre", 32'(awvalid), 32'h1);
    rbase = n_rsp;
    #2 ARESETN = 1'b0;
    #1;
    check("rst_mid_valids", 32'({awvalid, wvalid}), 32'h0);
    check("rst_mid_rsp_state", 32'({rsp_valid, rsp_resp}), 32'h0);
    check("rst_mid_rdata", rsp_rdata, 32'h0);
    aw_delay = 0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    base = n_gnt;
    drive(0, 1'b0, 4'h0, 32'h0);
    drive(1, 1'b0, 4'h4, 32'h0);
    wait_gnt(0, gc);
    #2;
    check("rst_first_gnt", 32'(gnt_idx_log[base]), 32'h0);
    @(negedge ACLK);
    req_valid[0] = 1'b0;
    wait_gnt(1, gc);
    @(negedge ACLK);
    req_valid[1] = 1'b0;
    wait_rsp(1, rc);
    #2;
    check("rst_rsp_count", 32'(n_rsp - rbase), 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
